// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between m0 (fetch) and m1 (load/store).
// m1 may lock the RAM for up to LOCK_MAX grants. Responses are registered and arrive one cycle after the grant.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4,
    parameter int PRIO_INIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t           state_q, state_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  force_m0_q, force_m0_d;
    logic                  last_gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  oor0, oor1, any_gnt, sel_we, sel_oor;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};
    assign oor0 = |m0_addr[31:ADDR_WIDTH+2];
    assign oor1 = |m1_addr[31:ADDR_WIDTH+2];

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            // The cycle after a forced release belongs to m0; otherwise the lock or round-robin decides.
            m0_gnt = m0_req && (!m1_req || force_m0_q ||
                                (state_q == UNLOCKED && last_gnt_q));
            m1_gnt = m1_req && !m0_gnt;
        end
        any_gnt   = m0_gnt || m1_gnt;
        sel_we    = m1_gnt ? m1_we    : m0_we;
        sel_addr  = m1_gnt ? m1_addr  : m0_addr;
        sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
        sel_oor   = m1_gnt ? oor1     : oor0;
        ram_we    = any_gnt && sel_we && !sel_oor;
        ram_addr  = any_gnt ? sel_addr[ADDR_WIDTH+1:2] : addr_q;
        ram_wdata = any_gnt ? sel_wdata : wdata_q;
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        force_m0_d = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (m1_gnt && m1_lock && !force_m0_q) begin
                    if (LOCK_MAX <= 1) begin
                        force_m0_d = 1'b1;
                    end else begin
                        state_d    = LOCKED;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            LOCKED: begin
                if (!m1_req || !m1_lock) begin
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q + 1'b1 == LOCK_MAX_C) begin
                    // m1 is granted here; this grant uses up the lock budget.
                    state_d    = UNLOCKED;
                    lock_cnt_d = '0;
                    force_m0_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            force_m0_q <= 1'b0;
            last_gnt_q <= 1'(PRIO_INIT);
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_rvalid  <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            force_m0_q <= force_m0_d;
            if (any_gnt) begin
                last_gnt_q <= m1_gnt;
                addr_q     <= ram_addr;
                wdata_q    <= ram_wdata;
            end
            m0_rvalid <= m0_gnt;
            m0_err    <= m0_gnt && oor0;
            if (m0_gnt) m0_rdata <= (m0_we || oor0) ? '0 : ram_rdata;
            m1_rvalid <= m1_gnt;
            m1_err    <= m1_gnt && oor1;
            if (m1_gnt) m1_rdata <= (m1_we || oor1) ? '0 : ram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed sequences, a vector table and random traffic checked against a cycle model.
module tb_ram_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int LM = 4;
    localparam int PI = 1;

    logic          clk, rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
    logic [31:0]   m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid, m1_err;
    logic [31:0]   m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM), .PRIO_INIT(PI)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM instance model with a backdoor port used for preloading while the DUT is in reset.
    logic [DW-1:0] mem [0:2047];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    typedef struct {
        logic        rst, r0, we0;
        logic [31:0] a0, d0;
        logic        r1, we1, lk;
        logic [31:0] a1, d1;
        logic        g0, g1, rwe;
    } vec_t;

    // Reference model state
    logic [DW-1:0] ref_mem [0:2047];
    int            ref_last, ref_run, ref_force;
    logic          exp_rv [2];
    logic          exp_err [2];
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            addr_known;
    int            n_checks, n_fail;

    function automatic vec_t mk(logic rs, logic r0, logic we0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic we1, logic lk, logic [31:0] a1, logic [31:0] d1,
                                logic g0, logic g1, logic rwe);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.lk = lk; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rwe = rwe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input bit use_tbl);
        int          g;
        logic        we, oor;
        logic [31:0] a, d;
        logic [AW-1:0] word;
        @(negedge clk);
        check("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, exp_rv[0]});
        check("m0_rdata", m0_rdata, exp_rd[0]);
        check("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, exp_rv[1]});
        check("m1_rdata", m1_rdata, exp_rd[1]);
        if (exp_rv[0]) check("m0_err", {31'b0, m0_err}, {31'b0, exp_err[0]});
        if (exp_rv[1]) check("m1_err", {31'b0, m1_err}, {31'b0, exp_err[1]});
        rst = v.rst;
        m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.we1; m1_lock = v.lk; m1_addr = v.a1; m1_wdata = v.d1;
        #1;
        // Winner from the arbitration rules
        if (v.rst || (!v.r0 && !v.r1)) g = -1;
        else if (v.r0 && !v.r1)         g = 0;
        else if (!v.r0 && v.r1)         g = 1;
        else if (ref_force != 0)        g = 0;
        else if (ref_run > 0)           g = 1;
        else                            g = 1 - ref_last;
        check("m0_gnt", {31'b0, m0_gnt}, (g == 0) ? 32'd1 : 32'd0);
        check("m1_gnt", {31'b0, m1_gnt}, (g == 1) ? 32'd1 : 32'd0);
        if (use_tbl) begin
            check("tbl_m0_gnt", {31'b0, m0_gnt}, {31'b0, v.g0});
            check("tbl_m1_gnt", {31'b0, m1_gnt}, {31'b0, v.g1});
            check("tbl_ram_we", {31'b0, ram_we}, {31'b0, v.rwe});
        end
        we = (g == 1) ? v.we1 : v.we0;
        a  = (g == 1) ? v.a1  : v.a0;
        d  = (g == 1) ? v.d1  : v.d0;
        oor  = (a >> (AW + 2)) != 0;
        word = a[AW+1:2];
        if (g >= 0) begin
            check("ram_we", {31'b0, ram_we}, {31'b0, we && !oor});
            check("ram_addr", 32'(ram_addr), 32'(word));
            check("ram_wdata", ram_wdata, d);
            exp_addr = word; exp_wdata = d; addr_known = 1;
        end else begin
            check("ram_we_idle", {31'b0, ram_we}, 32'd0);
            if (addr_known) begin
                check("ram_addr_hold", 32'(ram_addr), 32'(exp_addr));
                check("ram_wdata_hold", ram_wdata, exp_wdata);
            end
        end
        if (v.rst) begin
            for (int i = 0; i < 2; i++) begin
                exp_rv[i] = 0; exp_rd[i] = '0; exp_err[i] = 0;
            end
            ref_last = PI; ref_run = 0; ref_force = 0; addr_known = 0;
        end else begin
            int nf;
            for (int i = 0; i < 2; i++) begin
                exp_rv[i] = (g == i);
                if (g == i) begin
                    exp_err[i] = oor;
                    exp_rd[i]  = (oor || we) ? '0 : ref_mem[word];
                end
            end
            if (g >= 0 && we && !oor) ref_mem[word] = d;
            // A lock lasts over consecutive locked m1 grants, at most LM of them.
            nf = 0;
            if (g == 1 && v.lk && (ref_run > 0 || ref_force == 0)) begin
                ref_run++;
                if (ref_run >= LM) begin ref_run = 0; nf = 1; end
            end else begin
                ref_run = 0;
            end
            ref_force = nf;
            if (g >= 0) ref_last = g;
        end
    endtask

    vec_t tbl [28];
    vec_t rv;
    logic [31:0] ra0, ra1;

    initial begin
        n_checks = 0; n_fail = 0;
        ref_last = PI; ref_run = 0; ref_force = 0; addr_known = 0;
        for (int i = 0; i < 2; i++) begin exp_rv[i] = 0; exp_rd[i] = '0; exp_err[i] = 0; end
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        rst = 1; bd_we = 0; bd_addr = '0; bd_data = '0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;

        for (int i = 0; i < 64; i++) begin
            logic [DW-1:0] val;
            val = (i == 0) ? 32'h0BAD_F00D : (i == 5) ? 32'hDEAD_BEEF : $urandom;
            @(negedge clk);
            bd_we = 1; bd_addr = AW'(i); bd_data = val;
            ref_mem[i] = val;
        end
        @(negedge clk);
        bd_we = 0;

        // Directed sequences with literal expectations
        step(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,0), 0);
        step(mk(0, 1,0,32'h14,0, 0,0,0,0,0, 0,0,0), 0);
        @(posedge clk); #1;
        check("seq_rd_rvalid", {31'b0, m0_rvalid}, 32'd1);
        check("seq_rd_data", m0_rdata, 32'hDEAD_BEEF);
        check("seq_rd_err", {31'b0, m0_err}, 32'd0);
        step(mk(0, 0,0,0,0, 1,1,0,32'h20,32'h1234_5678, 0,0,0), 0);
        @(posedge clk); #1;
        check("seq_wr_mem", mem[8], 32'h1234_5678);
        check("seq_wr_rdata", m1_rdata, 32'd0);
        step(mk(0, 0,0,0,0, 1,0,0,32'h20,0, 0,0,0), 0);
        @(posedge clk); #1;
        check("seq_wr_readback", m1_rdata, 32'h1234_5678);
        step(mk(0, 1,1,32'h2000,32'hFFFF_FFFF, 0,0,0,0,0, 0,0,0), 0);
        @(posedge clk); #1;
        check("seq_oor_err", {31'b0, m0_err}, 32'd1);
        check("seq_oor_rdata", m0_rdata, 32'd0);
        check("seq_oor_word0", mem[0], 32'h0BAD_F00D);

        // rst,r0,we0,a0,d0, r1,we1,lk,a1,d1, g0,g1,ram_we
        tbl[0]  = mk(1, 0,0,0,0,                       0,0,0,0,0,                       0,0,0);
        tbl[1]  = mk(1, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  0,0,0);
        tbl[2]  = mk(0, 1,0,32'h14,0,                  0,0,0,0,0,                       1,0,0);
        tbl[3]  = mk(0, 0,0,0,0,                       0,0,0,0,0,                       0,0,0);
        tbl[4]  = mk(1, 0,0,0,0,                       0,0,0,0,0,                       0,0,0);
        tbl[5]  = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  1,0,0);
        tbl[6]  = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  0,1,0);
        tbl[7]  = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  1,0,0);
        tbl[8]  = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  0,1,0);
        tbl[9]  = mk(0, 0,0,0,0,                       1,1,0,32'h20,32'h1234_5678,      0,1,1);
        tbl[10] = mk(0, 0,0,0,0,                       1,0,0,32'h20,0,                  0,1,0);
        tbl[11] = mk(0, 1,1,32'h2000,32'hFFFF_FFFF,    0,0,0,0,0,                       1,0,0);
        tbl[12] = mk(0, 1,0,32'h0,0,                   0,0,0,0,0,                       1,0,0);
        tbl[13] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[14] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[15] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[16] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[17] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  1,0,0);
        tbl[18] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[19] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[20] = mk(1, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,0,0);
        tbl[21] = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  1,0,0);
        tbl[22] = mk(0, 1,0,32'h14,0,                  1,0,1,32'h18,0,                  0,1,0);
        tbl[23] = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  0,1,0);
        tbl[24] = mk(0, 1,0,32'h14,0,                  1,0,0,32'h18,0,                  1,0,0);
        tbl[25] = mk(0, 0,0,0,0,                       1,1,1,32'h24,32'hA5A5_0F0F,      0,1,1);
        tbl[26] = mk(0, 1,0,32'h24,0,                  0,0,0,0,0,                       1,0,0);
        tbl[27] = mk(0, 1,0,32'h14,0,                  1,1,1,32'h2004,32'h5555_AAAA,    0,1,0);
        for (int i = 0; i < 28; i++) step(tbl[i], 1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            ra0 = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom)};
            ra1 = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) ra0 = ra0 | (32'h1 << (AW + 2 + $urandom_range(0, 18)));
            if ($urandom_range(0, 15) == 0) ra1 = ra1 | (32'h1 << (AW + 2 + $urandom_range(0, 18)));
            rv = mk($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, ra0, $urandom,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) != 0, ra1, $urandom,
                    0, 0, 0);
            step(rv, 0);
        end
        step(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 2048x32 data RAM between two requesters: m0 (instruction fetch) and m1 (load/store unit).
- Each cycle, at most one requester is granted the RAM. Arbitration is round-robin, and m1 can request a bounded lock for read-modify-write sequences.
- The block registers the read data and returns it one cycle after the grant, so RAM read timing is decoupled from the pipeline.
- It sits between the core's memory stages and the RAM instance.

Parameters:
- ADDR_WIDTH, 11, RAM word-address width (2^ADDR_WIDTH words).
- DATA_WIDTH, 32, data word width.
- LOCK_MAX, 4, maximum consecutive locked grants to m1 before a forced release.
- PRIO_INIT, 1, value of the last-grant pointer after reset (1 means m0 wins the first tie).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  m0 access request.
- m0_we  in  1  m0 write enable.
- m0_addr  in  32  m0 byte address.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  m0 access performed this cycle.
- m0_rvalid  out  1  m0 response valid.
- m0_rdata  out  DATA_WIDTH  m0 read data.
- m0_err  out  1  m0 response is an address error.
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/32/DATA_WIDTH  same meanings, for m1.
- m1_lock  in  1  m1 requests to keep the grant.
- m1_gnt, m1_rvalid, m1_rdata, m1_err  out  same meanings, for m1.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - Registered outputs: all mX_rvalid, mX_rdata and mX_err are 0.
  - Internal state: last_gnt = PRIO_INIT, lock_active = 0, lock_cnt = 0.
  - Combinational outputs: m0_gnt, m1_gnt and ram_we are forced to 0 while rst = 1.
- Address handling:
  - Word address = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored.
  - The address is out of range if any bit of addr[31:ADDR_WIDTH+2] is set.
- Grant (combinational, same cycle as the request):
  - Only one requester active: that requester is granted.
  - Both requesting, lock_active = 1: m1 is granted.
  - Both requesting otherwise: the requester not equal to last_gnt is granted.
  - Neither requesting: no grant, ram_we = 0, ram_addr and ram_wdata hold their last values.
- RAM drive:
  - The granted requester's signals drive the RAM.
  - ram_we = granted mX_we AND in-range.
  - An out-of-range write never reaches the RAM.
- Response (registered, 1-cycle latency):
  - On the edge after a grant, the granted requester gets mX_rvalid = 1.
  - For a read: mX_rdata = ram_rdata sampled at that edge, i.e. the value before any write in the same cycle.
  - For a write: mX_rdata = 0.
  - For an out-of-range access: mX_err = 1 and mX_rdata = 0.
  - A non-granted requester's rvalid is 0, and its rdata holds its previous value.
  - Back-to-back grants to the same requester give rvalid on consecutive cycles.
- last_gnt update: updated to the granted id on every grant; unchanged when idle.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED: m1 granted with m1_lock = 1. lock_cnt is set to 1.
  - In LOCKED, each m1 grant increments lock_cnt.
  - LOCKED -> UNLOCKED when m1_req = 0, m1_lock = 0, or lock_cnt = LOCK_MAX.
  - On the forced release at LOCK_MAX: for the next cycle, if m0_req = 1, m0 is granted regardless of last_gnt. A new lock may start only after that cycle.
  - m0 therefore waits at most LOCK_MAX+1 cycles.
- Other rules:
  - m0_req is held until m0_gnt; the arbiter does not queue requests.
  - A request dropped before grant is lost with no response.
  - Reset mid-lock: the FSM returns to UNLOCKED, and any pending rvalid is suppressed.

Test Plan:
- Single read, m0 only: rst, then preload word 5 = 0xDEADBEEF; m0_req=1, addr=0x14 → m0_gnt=1 same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0.
- Contention: both request for 4 cycles with m1_lock=0 → grants alternate m0,m1,m0,m1 (PRIO_INIT=1); each rvalid one cycle later.
- Write then read by m1: write addr=0x20, wdata=0x12345678 → ram_we=1, ram_addr=8. Next cycle, read addr=0x20 → m1_rdata=0x12345678.
- Lock starvation bound: m0_req and m1_req held, m1_lock=1 continuously, LOCK_MAX=4 → m1 granted 4 cycles, then m0 granted 1 cycle, then m1 relocks.
- Out-of-range: m0 write addr=0x00002000 → ram_we=0, m0_rvalid=1 with m0_err=1, m0_rdata=0; RAM word 0 unchanged.
- Reset mid-lock: assert rst while LOCKED with lock_cnt=2 → next cycle all rvalid=0, m0 wins the first tie after reset.
